// File: rtl/display_panel_receiver_if.sv
// Panel-side bus between display_driver (master) and display_panel_receiver (slave).
// Signalling: there is no valid/ready pairing on this bus. oclk and lat are
// strobes whose rising edge (sampled in the receiver clock domain) is the event;
// a strobe held high is one event, and each event needs at least one low sample
// before the next. rgb/row are qualified by those edges, and oe is a level.
interface display_panel_receiver_if #(
    parameter int segments = 1,
    parameter int rows     = 8
);
    logic                    oclk;
    logic                    lat;
    logic                    oe;
    logic [3*segments-1:0]   rgb;
    logic [$clog2(rows)-1:0] row;

    modport master (output oclk, lat, oe, rgb, row);
    modport slave  (input  oclk, lat, oe, rgb, row);
endinterface

// File: rtl/display_panel_receiver.sv
// Sink-side model of an LED-matrix panel. It shifts rgb in on oclk edges, latches
// the shifted line on lat edges, and measures the per-row oe on-time of each frame.
// A frame closes when the latched row wraps from rows-1 back to 0.
module display_panel_receiver #(
    parameter int segments = 1,
    parameter int rows     = 8,
    parameter int columns  = 32,
    parameter int cntwidth = 24
) (
    input  logic                            clk,
    input  logic                            rst,
    display_panel_receiver_if.slave         bus,
    output logic [3*segments*columns-1:0]   o_line_data,
    output logic [$clog2(rows)-1:0]         o_line_row,
    output logic                            o_line_valid,
    output logic                            o_line_err,
    output logic                            o_frame_done,
    output logic [cntwidth-1:0]             o_frame_cycles,
    input  logic [$clog2(rows)-1:0]         i_rd_row,
    output logic [cntwidth-1:0]             o_rd_ontime,
    output logic [1:0]                      o_line_state
);
    localparam int SW = 3 * segments;
    localparam int LW = SW * columns;
    localparam int RW = $clog2(rows);
    localparam int CW = $clog2(columns + 1);

    localparam logic [CW-1:0]       CNT_FULL = CW'(columns);
    localparam logic [RW-1:0]       ROW_LAST = RW'(rows - 1);
    localparam logic [cntwidth-1:0] CNT_SAT  = '1;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_SHIFTING = 2'd1,
        ST_FULL     = 2'd2,
        ST_OVERRUN  = 2'd3
    } line_state_t;

    // Input stage. Only the strobes need a second stage for edge detection;
    // data, row and oe are consumed straight from the first stage.
    logic          r_oclk_q;
    logic          r_oclk_qq;
    logic          r_lat_q;
    logic          r_lat_qq;
    logic          r_oe_q;
    logic [SW-1:0] r_rgb_q;
    logic [RW-1:0] r_row_q;

    // Line capture state
    line_state_t   r_state;
    logic [LW-1:0] r_shreg;
    logic [CW-1:0] r_cnt;
    logic          r_overrun;

    // On-time accounting
    logic [cntwidth-1:0] r_acc  [rows];
    logic [cntwidth-1:0] r_bank [rows];
    logic [cntwidth-1:0] r_cyc;

    logic                w_oclk_edge;
    logic                w_lat_edge;
    logic                w_full;
    logic [LW-1:0]       w_shreg_next;
    logic [CW-1:0]       w_cnt_next;
    logic                w_ovr_next;
    logic                w_wrap;
    logic [cntwidth-1:0] w_cyc_inc;
    logic [cntwidth-1:0] w_acc_next [rows];

    // Register the panel pins once (and the strobes twice) in the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oclk_q  <= 1'b0;
            r_oclk_qq <= 1'b0;
            r_lat_q   <= 1'b0;
            r_lat_qq  <= 1'b0;
            r_oe_q    <= 1'b0;
            r_rgb_q   <= '0;
            r_row_q   <= '0;
        end else begin
            r_oclk_q  <= bus.oclk;
            r_oclk_qq <= r_oclk_q;
            r_lat_q   <= bus.lat;
            r_lat_qq  <= r_lat_q;
            r_oe_q    <= bus.oe;
            r_rgb_q   <= bus.rgb;
            r_row_q   <= bus.row;
        end
    end

    assign w_oclk_edge = r_oclk_q & ~r_oclk_qq;
    assign w_lat_edge  = r_lat_q & ~r_lat_qq;
    assign w_full      = (r_cnt == CNT_FULL);

    // Shift is resolved before any latch in the same cycle, so a coincident
    // oclk edge contributes its bit and its count to the latched line.
    assign w_shreg_next = w_oclk_edge ? {r_shreg[LW-SW-1:0], r_rgb_q} : r_shreg;
    assign w_cnt_next   = (w_oclk_edge && !w_full) ? r_cnt + CW'(1) : r_cnt;
    assign w_ovr_next   = r_overrun | (w_oclk_edge & w_full);

    // A frame closes on a latch that wraps the row address from the last row to 0
    assign w_wrap = w_lat_edge && (r_row_q == '0) && (o_line_row == ROW_LAST);

    assign w_cyc_inc = (r_cyc == CNT_SAT) ? r_cyc : r_cyc + cntwidth'(1);

    // Per-row saturating on-time increment charged to the currently latched row
    always_comb begin
        for (int k = 0; k < rows; k++) begin
            w_acc_next[k] = r_acc[k];
            if (r_oe_q && (o_line_row == RW'(k)) && (r_acc[k] != CNT_SAT)) begin
                w_acc_next[k] = r_acc[k] + cntwidth'(1);
            end
        end
    end

    // Line FSM: shift register, shift count, overrun flag and latched line outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_EMPTY;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_overrun    <= 1'b0;
            o_line_data  <= '0;
            o_line_row   <= '0;
            o_line_valid <= 1'b0;
            o_line_err   <= 1'b0;
        end else begin
            o_line_valid <= 1'b0;
            o_line_err   <= 1'b0;
            r_shreg      <= w_shreg_next;
            if (w_lat_edge) begin
                o_line_data  <= w_shreg_next;
                o_line_row   <= r_row_q;
                o_line_valid <= 1'b1;
                o_line_err   <= (w_cnt_next != CNT_FULL) || w_ovr_next;
                r_cnt        <= '0;
                r_overrun    <= 1'b0;
                r_state      <= ST_EMPTY;
            end else begin
                r_cnt     <= w_cnt_next;
                r_overrun <= w_ovr_next;
                if (w_ovr_next) begin
                    r_state <= ST_OVERRUN;
                end else if (w_cnt_next == CNT_FULL) begin
                    r_state <= ST_FULL;
                end else if (w_cnt_next == '0) begin
                    r_state <= ST_EMPTY;
                end else begin
                    r_state <= ST_SHIFTING;
                end
            end
        end
    end

    // Accumulate on-time per row; snapshot and restart the accumulators at a wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < rows; k++) begin
                r_acc[k]  <= '0;
                r_bank[k] <= '0;
            end
        end else begin
            for (int k = 0; k < rows; k++) begin
                if (w_wrap) begin
                    r_bank[k] <= w_acc_next[k];
                    r_acc[k]  <= '0;
                end else begin
                    r_acc[k]  <= w_acc_next[k];
                end
            end
        end
    end

    // Frame length counter; the wrap cycle itself belongs to the closing frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc          <= '0;
            o_frame_cycles <= '0;
            o_frame_done   <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            if (w_wrap) begin
                o_frame_cycles <= w_cyc_inc;
                o_frame_done   <= 1'b1;
                r_cyc          <= '0;
            end else begin
                r_cyc <= w_cyc_inc;
            end
        end
    end

    assign o_rd_ontime  = r_bank[i_rd_row];
    assign o_line_state = r_state;

endmodule

// File: tb/tb_display_panel_receiver.sv
// Bench for display_panel_receiver. Two instances share one panel bus: a full
// width one and a 4-bit-counter one that exercises saturation. Outputs are
// compared against a pin-level reference model of the panel behaviour.
`timescale 1ns/1ps
module tb_display_panel_receiver;
    localparam int SEG    = 1;
    localparam int ROWS   = 8;
    localparam int COLS   = 32;
    localparam int CNTW_A = 24;
    localparam int CNTW_B = 4;
    localparam int SW     = 3 * SEG;
    localparam int LW     = SW * COLS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    display_panel_receiver_if #(.segments(SEG), .rows(ROWS)) bus ();

    logic [2:0]        rd_row;
    logic [LW-1:0]     a_line_data,    b_line_data;
    logic [2:0]        a_line_row,     b_line_row;
    logic              a_line_valid,   b_line_valid;
    logic              a_line_err,     b_line_err;
    logic              a_frame_done,   b_frame_done;
    logic [CNTW_A-1:0] a_frame_cycles, a_rd_ontime;
    logic [CNTW_B-1:0] b_frame_cycles, b_rd_ontime;
    logic [1:0]        a_state,        b_state;

    display_panel_receiver #(.segments(SEG), .rows(ROWS), .columns(COLS), .cntwidth(CNTW_A)) dut_a (
        .clk(clk), .rst(rst), .bus(bus),
        .o_line_data(a_line_data), .o_line_row(a_line_row), .o_line_valid(a_line_valid),
        .o_line_err(a_line_err), .o_frame_done(a_frame_done), .o_frame_cycles(a_frame_cycles),
        .i_rd_row(rd_row), .o_rd_ontime(a_rd_ontime), .o_line_state(a_state)
    );

    display_panel_receiver #(.segments(SEG), .rows(ROWS), .columns(COLS), .cntwidth(CNTW_B)) dut_b (
        .clk(clk), .rst(rst), .bus(bus),
        .o_line_data(b_line_data), .o_line_row(b_line_row), .o_line_valid(b_line_valid),
        .o_line_err(b_line_err), .o_frame_done(b_frame_done), .o_frame_cycles(b_frame_cycles),
        .i_rd_row(rd_row), .o_rd_ontime(b_rd_ontime), .o_line_state(b_state)
    );

    // ---------------- reference model ----------------
    logic [SW-1:0]  hist [$];          // last COLS shifted values, oldest first
    logic [LW-1:0]  exp_q [$];         // expected line data awaiting line_valid
    int             n_shift;
    int             m_row;
    longint         m_acc  [ROWS];
    longint         m_bank [ROWS];
    longint         m_cyc;
    int             m_wraps;
    bit             p_oclk, p_lat;
    bit             e_valid, e_err, e_done;
    logic [2:0]     e_row;
    longint         e_fc;
    int             tb_cyc;
    int             n_checks;
    int             n_errors;
    bit             rand_oe;

    function automatic longint sat(input longint v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (v > m) ? m : v;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < COLS; i++) hist.push_back('0);
        exp_q.delete();
        n_shift = 0;
        m_row   = 0;
        for (int k = 0; k < ROWS; k++) begin
            m_acc[k]  = 0;
            m_bank[k] = 0;
        end
        m_cyc   = 1;
        p_oclk  = 1'b0;
        p_lat   = 1'b0;
        e_valid = 1'b0;
        e_err   = 1'b0;
        e_done  = 1'b0;
        e_row   = '0;
        e_fc    = 0;
    endtask

    // One clock of panel behaviour from the sampled pins: on-time first, then
    // shift, then latch (a coincident shift lands in the latched line).
    task automatic model_sample();
        logic [LW-1:0] d;
        e_valid = 1'b0;
        e_err   = 1'b0;
        e_done  = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        m_cyc++;
        if (bus.oe) m_acc[m_row]++;
        if (bus.oclk && !p_oclk) begin
            hist.push_back(bus.rgb);
            void'(hist.pop_front());
            n_shift++;
        end
        if (bus.lat && !p_lat) begin
            for (int c = 0; c < COLS; c++) d[SW*c +: SW] = hist[COLS-1-c];
            exp_q.push_back(d);
            e_valid = 1'b1;
            e_err   = (n_shift != COLS);
            e_row   = bus.row;
            n_shift = 0;
            if (bus.row == 3'd0 && m_row == ROWS - 1) begin
                for (int k = 0; k < ROWS; k++) begin
                    m_bank[k] = m_acc[k];
                    m_acc[k]  = 0;
                end
                e_fc   = m_cyc;
                m_cyc  = 0;
                e_done = 1'b1;
                m_wraps++;
            end
            m_row = int'(bus.row);
        end
        p_oclk = bus.oclk;
        p_lat  = bus.lat;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: model samples at posedge, outputs checked at the following negedge
    task automatic step();
        bit         s_valid, s_err, s_done;
        logic [2:0] s_row;
        longint     s_fc;
        logic [LW-1:0] d;
        @(posedge clk);
        tb_cyc++;
        s_valid = e_valid;
        s_err   = e_err;
        s_done  = e_done;
        s_row   = e_row;
        s_fc    = e_fc;
        model_sample();
        @(negedge clk);
        chk("line_valid_a", LW'(a_line_valid), LW'(s_valid));
        chk("line_valid_b", LW'(b_line_valid), LW'(s_valid));
        chk("frame_done_a", LW'(a_frame_done), LW'(s_done));
        chk("frame_done_b", LW'(b_frame_done), LW'(s_done));
        if (s_valid) begin
            d = exp_q.pop_front();
            chk("line_err_a",  LW'(a_line_err), LW'(s_err));
            chk("line_err_b",  LW'(b_line_err), LW'(s_err));
            chk("line_row_a",  LW'(a_line_row), LW'(s_row));
            chk("line_data_a", a_line_data, d);
            chk("line_data_b", b_line_data, d);
        end
        if (s_done) begin
            chk("frame_cycles_a", LW'(a_frame_cycles), LW'(sat(s_fc, CNTW_A)));
            chk("frame_cycles_b", LW'(b_frame_cycles), LW'(sat(s_fc, CNTW_B)));
        end
        if (rand_oe) bus.oe = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse(input logic [SW-1:0] v, input int hi, input int lo);
        bus.rgb  = v;
        bus.oclk = 1'b1;
        repeat (hi) step();
        bus.oclk = 1'b0;
        repeat (lo) step();
    endtask

    task automatic latch(input int r);
        bus.row = 3'(r);
        bus.lat = 1'b1;
        step();
        bus.lat = 1'b0;
        step();
    endtask

    task automatic pulse_and_latch(input logic [SW-1:0] v, input int r);
        bus.rgb  = v;
        bus.row  = 3'(r);
        bus.oclk = 1'b1;
        bus.lat  = 1'b1;
        step();
        bus.oclk = 1'b0;
        bus.lat  = 1'b0;
        step();
    endtask

    // Sweep readback of every row within the low half of the clock
    task automatic check_bank();
        for (int k = 0; k < ROWS; k++) begin
            rd_row = 3'(k);
            #0.4;
            chk("rd_ontime_a", LW'(a_rd_ontime), LW'(sat(m_bank[k], CNTW_A)));
            chk("rd_ontime_b", LW'(b_rd_ontime), LW'(sat(m_bank[k], CNTW_B)));
        end
        rd_row = '0;
    endtask

    task automatic do_reset(input int cycles);
        rst      = 1'b1;
        bus.oclk = 1'b0;
        bus.lat  = 1'b0;
        bus.oe   = 1'b0;
        bus.rgb  = '0;
        bus.row  = '0;
        rd_row   = 3'($urandom_range(0, ROWS - 1));
        model_reset();
        #1;
        chk("rst_line_data",    a_line_data | b_line_data, '0);
        chk("rst_line_row",     LW'(a_line_row | b_line_row), '0);
        chk("rst_line_valid",   LW'(a_line_valid | b_line_valid), '0);
        chk("rst_line_err",     LW'(a_line_err | b_line_err), '0);
        chk("rst_frame_done",   LW'(a_frame_done | b_frame_done), '0);
        chk("rst_frame_cycles", LW'(a_frame_cycles) | LW'(b_frame_cycles), '0);
        chk("rst_rd_ontime",    LW'(a_rd_ontime) | LW'(b_rd_ontime), '0);
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [LW-1:0]  all101;
        logic [SW-1:0]  v;
        int             t_wrap1, t_wrap2, r, n, w0;

        n_checks = 0;
        n_errors = 0;
        tb_cyc   = 0;
        m_wraps  = 0;
        rand_oe  = 1'b0;
        do_reset(3);

        // 1: full line of 3'b101 latched on row 3
        for (int i = 0; i < COLS; i++) pulse(3'b101, 1, 1);
        latch(3);
        for (int c = 0; c < COLS; c++) all101[SW*c +: SW] = 3'b101;
        chk("t1_line_data", a_line_data, all101);
        chk("t1_line_row",  LW'(a_line_row), LW'(3));

        // 2: short line and overrun line both flag an error
        for (int i = 0; i < COLS - 1; i++) pulse(3'($urandom_range(0, 7)), 1, 1);
        latch(4);
        for (int i = 0; i < COLS; i++) pulse(3'($urandom_range(0, 7)), 1, 1);
        v = 3'($urandom_range(0, 7));
        pulse(v, 1, 1);
        latch(5);
        chk("t2_col0_33rd", LW'(a_line_data[SW-1:0]), LW'(v));

        // 3: 32nd oclk edge coincides with lat
        for (int i = 0; i < COLS - 1; i++) pulse(3'($urandom_range(0, 7)), 1, 1);
        v = 3'($urandom_range(0, 7));
        pulse_and_latch(v, 6);
        chk("t3_col0_32nd", LW'(a_line_data[SW-1:0]), LW'(v));
        chk("t3_line_err",  LW'(a_line_err), '0);

        // 4: full frame with 100 oe cycles per row between two wraps
        latch(7);
        latch(0);
        t_wrap1 = tb_cyc - 1;
        for (int k = 0; k < ROWS; k++) begin
            bus.oe = 1'b1;
            repeat (100) step();
            bus.oe = 1'b0;
            latch((k + 1) % ROWS);
        end
        t_wrap2 = tb_cyc - 1;
        chk("t4_frame_cycles", LW'(a_frame_cycles), LW'(t_wrap2 - t_wrap1));
        rd_row = 3'd5;
        #0.4;
        chk("t4_ontime_100", LW'(a_rd_ontime), LW'(100));
        chk("t4_ontime_sat", LW'(b_rd_ontime), LW'(15));
        check_bank();

        // 5: 40 oe cycles on one row saturate the 4-bit counter
        latch(7);
        latch(0);
        bus.oe = 1'b1;
        repeat (40) step();
        bus.oe = 1'b0;
        latch(7);
        latch(0);
        rd_row = 3'd0;
        #0.4;
        chk("t5_ontime_b", LW'(b_rd_ontime), LW'(15));
        chk("t5_ontime_a", LW'(a_rd_ontime), LW'(40));
        check_bank();

        // 6: reset in the middle of a line discards the partial shift
        for (int i = 0; i < 10; i++) pulse(3'($urandom_range(0, 7)), 1, 1);
        do_reset(2);
        for (int i = 0; i < COLS; i++) pulse(3'($urandom_range(0, 7)), 1, 1);
        latch(2);
        chk("t6_line_err", LW'(a_line_err), '0);

        // Random lines: varied counts, held strobes, random oe, mostly sequential rows
        rand_oe = 1'b1;
        for (int t = 0; t < 40; t++) begin
            n  = $urandom_range(COLS - 2, COLS + 2);
            w0 = m_wraps;
            for (int i = 0; i < n; i++) begin
                pulse(3'($urandom_range(0, 7)), $urandom_range(1, 2), $urandom_range(1, 2));
            end
            r = ($urandom_range(0, 9) < 8) ? (m_row + 1) % ROWS : $urandom_range(0, ROWS - 1);
            if ($urandom_range(0, 5) == 0) pulse_and_latch(3'($urandom_range(0, 7)), r);
            else latch(r);
            if (m_wraps != w0) check_bank();
        end
        rand_oe = 1'b0;
        bus.oe  = 1'b0;
        repeat (3) step();
        check_bank();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
